// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution engine and its pooling stage.
// Define CONV_POOL_SAT_EN to narrow pooled output to 8 bits with shift + saturation.
package conv_pkg;

  localparam int CONV_DW = 16;

`ifdef CONV_POOL_SAT_EN
  localparam bit SAT_EN  = 1'b1;
  localparam int POOL_DW = 8;
`else
  localparam bit SAT_EN  = 1'b0;
  localparam int POOL_DW = 16;
`endif

  function automatic logic [CONV_DW-1:0] max16(input logic [CONV_DW-1:0] a,
                                               input logic [CONV_DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Requantise a 16-bit maximum into 8 bits, clamping anything above 255.
  function automatic logic [7:0] sat8(input logic [CONV_DW-1:0] v, input int sh);
    logic [CONV_DW-1:0] s;
    s = v >> sh;
    return (s > 16'd255) ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/conv_max_pool_if.sv
// Result stream in / pooled stream out of the max-pool stage.
interface conv_max_pool_if;
  import conv_pkg::*;

  logic               in_valid;
  logic [CONV_DW-1:0] in_data;
  logic               out_ready;
  logic               out_valid;
  logic [POOL_DW-1:0] out_data;
  logic               frame_done;
  logic               overflow;

  modport master (output in_valid, in_data, out_ready,
                  input  out_valid, out_data, frame_done, overflow);
  modport slave  (input  in_valid, in_data, out_ready,
                  output out_valid, out_data, frame_done, overflow);
endinterface

// File: rtl/pool_out_fifo.sv
// Two-entry first-word-fall-through FIFO; a push into a full FIFO is taken
// only when a pop happens in the same cycle.
module pool_out_fifo #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_q, rd_q;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_push, do_pop;

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    do_pop  = pop_i & (cnt_q != 2'd0);
    do_push = push_i & ((cnt_q != 2'd2) | do_pop);
    cnt_d   = cnt_q;
    if (do_push && !do_pop)      cnt_d = cnt_q + 2'd1;
    else if (!do_push && do_pop) cnt_d = cnt_q - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the storage is reset too, so out_data reads 0 straight out of reset.
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= ~wr_q;
      end
      if (do_pop) rd_q <= ~rd_q;
      cnt_q <= cnt_d;
    end
  end

  assign data_o  = mem_q[rd_q];
  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/conv_max_pool.sv
// 2x2 stride-2 max pooling over the raster-ordered conv result stream.
// Output width and requantisation follow CONV_POOL_SAT_EN (see conv_pkg).
module conv_max_pool
  import conv_pkg::*;
#(
  parameter int OW    = 2,
  parameter int SHIFT = 0
) (
  input logic             clk,
  input logic             rst,
  conv_max_pool_if.slave  bus
);

  localparam int CW = $clog2(OW);
  localparam int NP = OW / 2;
  localparam int JW = (NP > 1) ? $clog2(NP) : 1;
  localparam int PW = 2 * NP;

  logic [CW-1:0]      col_q, col_d, row_q, row_d;
  logic [CONV_DW-1:0] pmax_q [NP];
  logic               frame_done_q, overflow_q;
  logic [JW-1:0]      j;
  logic               in_pool, first, last, push, pop;
  logic               fifo_full, fifo_empty;
  logic [CONV_DW-1:0] pool_max;
  logic [POOL_DW-1:0] push_data;

  always_comb begin
    j         = JW'(col_q >> 1);
    // A trailing odd row/column never closes a window, so it is excluded.
    in_pool   = (int'(col_q) < PW) && (int'(row_q) < PW);
    first     = ~row_q[0] & ~col_q[0];
    pool_max  = max16(pmax_q[j], bus.in_data);
    push      = bus.in_valid & in_pool & row_q[0] & col_q[0];
    pop       = bus.out_ready & ~fifo_empty;
    push_data = SAT_EN ? POOL_DW'(sat8(pool_max, SHIFT)) : POOL_DW'(pool_max);
    last      = bus.in_valid && (col_q == CW'(OW - 1)) && (row_q == CW'(OW - 1));
    col_d     = col_q;
    row_d     = row_q;
    if (bus.in_valid) begin
      if (col_q == CW'(OW - 1)) begin
        col_d = '0;
        row_d = (row_q == CW'(OW - 1)) ? '0 : row_q + CW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      for (int k = 0; k < NP; k++) pmax_q[k] <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      frame_done_q <= last;
      if (push && fifo_full && !pop) overflow_q <= 1'b1;
      if (bus.in_valid && in_pool) pmax_q[j] <= first ? bus.in_data : pool_max;
    end
  end

  pool_out_fifo #(.W(POOL_DW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (bus.out_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.out_valid  = ~fifo_empty;
  assign bus.frame_done = frame_done_q;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_conv_max_pool.sv
// Self-checking bench for conv_max_pool: three instances (OW=2,3,4) driven one
// at a time against a window/queue reference model.
`timescale 1ns/1ps
module tb_conv_max_pool;
  import conv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_max_pool_if if2 ();
  conv_max_pool_if if3 ();
  conv_max_pool_if if4 ();

  conv_max_pool #(.OW(2), .SHIFT(2)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));
  conv_max_pool #(.OW(3), .SHIFT(0)) u3 (.clk(clk), .rst(rst), .bus(if3.slave));
  conv_max_pool #(.OW(4), .SHIFT(0)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));

  int checks = 0;
  int errors = 0;

  // Reference model state: active instance (= its OW), frame image, queue of
  // values the FIFO should hold, and flags expected on the next sample.
  int sel = 4;
  int pos = 0;
  int frame [16];
  int exp_q [$];
  int got_q [$];
  bit fd_exp  = 1'b0;
  bit ovf_exp = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int pool_value(input int m, input int sh);
    int s;
    s = m >> sh;
    if (SAT_EN) return (s > 255) ? 255 : s;
    return m;
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  task automatic drive(input logic v, input logic [15:0] d, input logic rdy);
    if2.in_valid = 1'b0; if2.in_data = '0; if2.out_ready = 1'b1;
    if3.in_valid = 1'b0; if3.in_data = '0; if3.out_ready = 1'b1;
    if4.in_valid = 1'b0; if4.in_data = '0; if4.out_ready = 1'b1;
    case (sel)
      2:       begin if2.in_valid = v; if2.in_data = d; if2.out_ready = rdy; end
      3:       begin if3.in_valid = v; if3.in_data = d; if3.out_ready = rdy; end
      default: begin if4.in_valid = v; if4.in_data = d; if4.out_ready = rdy; end
    endcase
  endtask

  task automatic sample(output logic ov, output logic [31:0] od, output logic fd,
                        output logic ovf);
    case (sel)
      2:       begin ov = if2.out_valid; od = 32'(if2.out_data); fd = if2.frame_done; ovf = if2.overflow; end
      3:       begin ov = if3.out_valid; od = 32'(if3.out_data); fd = if3.frame_done; ovf = if3.overflow; end
      default: begin ov = if4.out_valid; od = 32'(if4.out_data); fd = if4.frame_done; ovf = if4.overflow; end
    endcase
  endtask

  // One clock: called and returns at a negedge; checks outputs, applies inputs,
  // then advances the model across the coming posedge.
  task automatic tick(input logic v, input logic [15:0] d, input logic rdy);
    logic ov, fd, ovf;
    logic [31:0] od;
    int r, c, m, ev;
    bit do_pop, do_push;
    drive(v, d, rdy);
    sample(ov, od, fd, ovf);
    check("out_valid", ov, exp_q.size() != 0);
    if (exp_q.size() != 0) check("out_data", od, exp_q[0]);
    check("frame_done", fd, fd_exp);
    check("overflow", ovf, ovf_exp);
    do_pop  = rdy && (exp_q.size() != 0);
    do_push = 1'b0;
    fd_exp  = 1'b0;
    m       = 0;
    if (v) begin
      r  = pos / sel;
      c  = pos % sel;
      ev = sel - (sel % 2);
      frame[pos] = int'(d);
      if ((r % 2 == 1) && (c % 2 == 1) && (r < ev) && (c < ev)) begin
        m = pool_value(max4(frame[pos], frame[pos-1], frame[pos-sel], frame[pos-sel-1]),
                       (sel == 2) ? 2 : 0);
        if (exp_q.size() < 2 || do_pop) do_push = 1'b1;
        else ovf_exp = 1'b1;
      end
      pos++;
      if (pos == sel * sel) begin
        pos    = 0;
        fd_exp = 1'b1;
      end
    end
    if (do_pop) begin
      got_q.push_back(int'(od));
      void'(exp_q.pop_front());
    end
    if (do_push) exp_q.push_back(m);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int s);
    logic ov, fd, ovf;
    logic [31:0] od;
    sel = s;
    drive(1'b0, 16'd0, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    got_q.delete();
    pos     = 0;
    fd_exp  = 1'b0;
    ovf_exp = 1'b0;
    sample(ov, od, fd, ovf);
    check("rst_out_valid", ov, 1'b0);
    check("rst_out_data", od, 0);
    check("rst_frame_done", fd, 1'b0);
    check("rst_overflow", ovf, 1'b0);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) tick(1'b0, 16'd0, rdy);
  endtask

  initial begin
    // 1: OW=4 ramp, always ready
    do_reset(4);
    for (int i = 1; i <= 16; i++) tick(1'b1, 16'(i), 1'b1);
    idle(4, 1'b1);
    check("t1_count", got_q.size(), 4);
    check("t1_out0", got_q[0], 6);
    check("t1_out1", got_q[1], 8);
    check("t1_out2", got_q[2], 14);
    check("t1_out3", got_q[3], 16);

    // 2: OW=2 single window
    do_reset(2);
    tick(1'b1, 16'd9, 1'b1);
    tick(1'b1, 16'd3, 1'b1);
    tick(1'b1, 16'd7, 1'b1);
    tick(1'b1, 16'd5, 1'b1);
    idle(3, 1'b1);
    check("t2_count", got_q.size(), 1);
    check("t2_out0", got_q[0], pool_value(9, 2));

    // 3: OW=4 with consumer stalled, then released
    do_reset(4);
    for (int i = 1; i <= 16; i++) tick(1'b1, 16'(i), 1'b0);
    idle(2, 1'b0);
    check("t3_overflow_model", if4.overflow, 1'b1);
    idle(5, 1'b1);
    check("t3_count", got_q.size(), 2);
    check("t3_out0", got_q[0], 6);
    check("t3_out1", got_q[1], 8);

    // 4: OW=3, trailing row/column ignored
    do_reset(3);
    for (int i = 1; i <= 9; i++) tick(1'b1, 16'(i), 1'b1);
    idle(3, 1'b1);
    check("t4_count", got_q.size(), 1);
    check("t4_out0", got_q[0], 5);

    // 5: reset mid-frame, then a fresh random frame
    do_reset(4);
    for (int i = 0; i < 5; i++) tick(1'b1, 16'($urandom), 1'b1);
    do_reset(4);
    for (int i = 0; i < 16; i++) tick(1'b1, 16'($urandom), 1'b1);
    idle(4, 1'b1);
    check("t5_count", got_q.size(), 4);
    check("t5_overflow", if4.overflow, 1'b0);

    // Random frames with gaps and random backpressure on every instance
    for (int s = 2; s <= 4; s++) begin
      do_reset(s);
      for (int f = 0; f < 6; f++) begin
        int sent;
        sent = 0;
        while (sent < s * s) begin
          if ($urandom_range(0, 3) != 0) begin
            tick(1'b1, 16'($urandom), 1'($urandom_range(0, 1)));
            sent++;
          end else begin
            tick(1'b0, 16'($urandom), 1'($urandom_range(0, 1)));
          end
        end
      end
      idle(6, 1'b1);
    end

`ifdef CONV_POOL_SAT_EN
    // 6: requantise and saturate on the OW=2 instance (SHIFT=2)
    do_reset(2);
    tick(1'b1, 16'd1000, 1'b1);
    tick(1'b1, 16'd4, 1'b1);
    tick(1'b1, 16'd4, 1'b1);
    tick(1'b1, 16'd4, 1'b1);
    tick(1'b1, 16'd2000, 1'b1);
    tick(1'b1, 16'd0, 1'b1);
    tick(1'b1, 16'd0, 1'b1);
    tick(1'b1, 16'd0, 1'b1);
    idle(3, 1'b1);
    check("t6_count", got_q.size(), 2);
    check("t6_out0", got_q[0], 250);
    check("t6_out1", got_q[1], 255);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
